fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end that drives the program counter into the instruction cache and consumes the returned 16-bit instruction.
- Holds the PC and registers each fetched word with its PC into a valid/ready pipeline register for the downstream decode/register-read stage.
- Supports back-pressure stalls, branch redirects that flush the pipeline register, and a halt opcode that stops fetching.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per fetched instruction.
- HALT_OPCODE, 4'hF, value of instruction[15:12] that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  16  byte address to the instruction cache counter input; always equals the current PC.
- imem_data  input  16  instruction word from the cache, combinational from imem_addr in the same cycle.
- redirect_valid  input  1  branch/jump redirect request; single-cycle pulse.
- redirect_pc  input  16  redirect target; bit 0 is ignored and treated as 0.
- out_valid  output  1  out_instruction and out_pc are valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_instruction  output  16  registered instruction.
- out_pc  output  16  PC of out_instruction.
- halted  output  1  high while in HALTED state.
- fetch_count  output  16  number of instructions captured since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any time, including mid-stall or while halted):
  - pc=RESET_PC; out_valid=0; out_instruction=0; out_pc=0; halted=0; fetch_count=0; state=FETCH.
  - A capture in flight is discarded.
- States: FETCH, HALTED.
- imem_addr = pc combinationally. Latency: the word at PC p appears on out_* one cycle after p is presented. Throughput is 1 instruction per cycle when out_ready is held high.
- Capture condition: state==FETCH && !redirect_valid && (!out_valid || out_ready). On capture:
  - out_instruction<=imem_data; out_pc<=pc; out_valid<=1.
  - pc<=pc+PC_STEP, mod 2^16: 16'hFFFE wraps to 16'h0000.
  - fetch_count increments unless already saturated.
- Stall (out_valid && !out_ready): pc, out_*, and fetch_count hold; out_instruction and out_pc stay stable until accepted.
- Drain without capture (out_valid && out_ready, no capture, e.g. HALTED): out_valid<=0.
- Halt:
  - A captured word with imem_data[15:12]==HALT_OPCODE is still emitted normally.
  - state<=HALTED the same edge; halted=1 from the next cycle.
  - pc holds at halt address+PC_STEP; no further captures.
  - The halt word remains valid until accepted, then out_valid drops.
- Redirect has the highest priority (after reset) and applies in any state:
  - pc<={redirect_pc[15:1],1'b0}; out_valid<=0 (flush, even if stalled and unaccepted); state<=FETCH; halted<=0.
  - No capture on that edge; fetch resumes the following cycle at the target.
  - A simultaneous out_ready handshake on a redirect cycle counts as accepted downstream; the word is then flushed.
- fetch_count is not affected by redirect.

Test Plan:
- ROM word k = 16'h1000+k, out_ready=1, release reset → imem_addr 0,2,4,...; out_pc 0,2,4 with out_instruction 1000,1001,1002 on consecutive cycles; fetch_count=3 after 3 captures.
- Drop out_ready for 3 cycles while out_pc=4 → out_instruction=1002 and out_pc=4 stable, imem_addr=6 held, fetch_count frozen; on release, next word 1003 at out_pc=6.
- Assert redirect_valid with redirect_pc=16'h0011 during a stall at out_pc=8 → next cycle out_valid=0 and imem_addr=16'h0010; following cycle out_pc=16'h0010 and out_instruction=1008.
- Word at PC 6 = 16'hF000 → emitted with out_pc=6; halted=1 next cycle; out_valid drops after acceptance; imem_addr stays 8; a redirect to 0 clears halted and fetch restarts at 0.
- Redirect to 16'hFFFE with out_ready=1 → captures at FFFE then 0000 (wrap).
- Assert reset mid-stream while out_valid=1 and fetch_count=5 → all outputs clear immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC/instruction-fetch front end with valid/ready output register, redirect flush and halt
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instruction,
  output logic [15:0] out_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state, state_next;
  logic [15:0] pc;
  logic capture;
  assign imem_addr = pc;
  assign halted = state == HALTED;
  assign capture = state == FETCH && !redirect_valid && (!out_valid || out_ready);
  always_comb begin
    state_next = state;
    state_next = redirect_valid ? FETCH
               : (capture && imem_data[15:12] == HALT_OPCODE) ? HALTED : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
      fetch_count     <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc        <= {redirect_pc[15:1], 1'b0};
        out_valid <= 1'b0;
      end else if (capture) begin
        out_instruction <= imem_data;
        out_pc          <= pc;
        out_valid       <= 1'b1;
        pc              <= pc + PC_STEP;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
